// File: rtl/contador_modular_if.sv
// Bus between a contador_modular stage and whoever drives it.
//
// Request signals (inc, dec, load, load_val) are plain levels. The counter is
// always ready and has no valid/ready pair. inc and dec count only on their
// rising edge. load is sampled on every clock. The response signals (count,
// carry, borrow, load_err) are registered in the counter; bcd is derived from
// count. carry, borrow and load_err are one-cycle pulses.
//
// Modports:
//   master : drives the requests and observes the outputs (testbench, time-set logic)
//   slave  : the counter itself
interface contador_modular_if #(
  parameter int WIDTH = 6
);
  logic             inc;
  logic             dec;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [7:0]       bcd;
  logic             carry;
  logic             borrow;
  logic             load_err;

  modport master (
    output inc, dec, load, load_val,
    input  count, bcd, carry, borrow, load_err
  );

  modport slave (
    input  inc, dec, load, load_val,
    output count, bcd, carry, borrow, load_err
  );
endinterface

// File: rtl/contador_modular.sv
// contador_modular: generic modulo-MODULO up/down counter for one clock stage
// (seconds, minutes or hours).
//
// Each rising edge of inc or dec moves the count by one. A wrap MODULO-1 -> 0
// produces a one-cycle carry, and a wrap 0 -> MODULO-1 produces a one-cycle
// borrow. Both pulses are used to chain to the next stage. A synchronous load
// sets the time. If the load value is out of range, the count holds and
// load_err pulses. bcd gives {tens, units} of the count to the display drivers.
//
// Ports:
//   clk_i  : clock, rising edge
//   rstn_i : asynchronous active-low reset
//   bus    : contador_modular_if.slave
//            inc, dec, load, load_val -> in
//            count, bcd, carry, borrow, load_err -> out
module contador_modular #(
  parameter int WIDTH     = 6,
  parameter int MODULO    = 60,
  parameter int RESET_VAL = 0,
  parameter int BCD_EN    = 1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  contador_modular_if.slave   bus
);

  // Elaboration-time parameter checks.
  if (MODULO < 2 || MODULO > (2 ** WIDTH)) begin : g_bad_modulo
    $error("contador_modular: MODULO=%0d outside 2..2**WIDTH", MODULO);
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULO) begin : g_bad_reset
    $error("contador_modular: RESET_VAL=%0d must be below MODULO", RESET_VAL);
  end
  if (BCD_EN != 0 && MODULO > 100) begin : g_bad_bcd
    $error("contador_modular: BCD_EN needs MODULO <= 100 (MODULO=%0d)", MODULO);
  end

  // MODULO may equal 2**WIDTH. Range compares therefore use one extra bit.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q;
  logic             carry_q;
  logic             borrow_q;
  logic             load_err_q;
  logic             inc_q;
  logic             dec_q;
  logic             inc_edge;
  logic             dec_edge;
  logic             load_ok;

  // The trackers clear in reset. An input that is already high at release
  // therefore counts as one edge.
  assign inc_edge = bus.inc & ~inc_q;
  assign dec_edge = bus.dec & ~dec_q;
  assign load_ok  = ({1'b0, bus.load_val} < MOD_EXT);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count_q    <= RST_VAL;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
    end else begin
      // The trackers update during load cycles too. A level held through a
      // load therefore does not count afterwards.
      inc_q      <= bus.inc;
      dec_q      <= bus.dec;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
      if (bus.load) begin
        if (load_ok) begin
          count_q <= bus.load_val;
        end else begin
          load_err_q <= 1'b1;
        end
      end else if (inc_edge && dec_edge) begin
        count_q <= count_q;  // simultaneous up and down cancel out
      end else if (inc_edge) begin
        if (count_q == TOP_VAL) begin
          count_q <= '0;
          carry_q <= 1'b1;
        end else begin
          count_q <= count_q + WIDTH'(1);
        end
      end else if (dec_edge) begin
        if (count_q == '0) begin
          count_q  <= TOP_VAL;
          borrow_q <= 1'b1;
        end else begin
          count_q <= count_q - WIDTH'(1);
        end
      end
    end
  end

  assign bus.count    = count_q;
  assign bus.carry    = carry_q;
  assign bus.borrow   = borrow_q;
  assign bus.load_err = load_err_q;

  if (BCD_EN != 0) begin : g_bcd
    // Division is done at 32 bits so that small WIDTH values cannot truncate
    // the constant 10. MODULO <= 100 keeps tens within 0..9.
    logic [31:0] count_ext;
    assign count_ext = 32'(count_q);
    assign bus.bcd   = {4'(count_ext / 32'd10), 4'(count_ext % 32'd10)};
  end else begin : g_no_bcd
    assign bus.bcd = 8'h00;
  end

endmodule
